// File: rtl/key_exp_pkg.sv
// ---------------------------------------------------------------------------
// DesignPkg
// Shared types and constants for the AES-128 key-expansion block.
//   key_t    : 128-bit round key, w0 = [127:96] ... w3 = [31:0]
//   word_t   : 32-bit key word
//   sbox_t   : one byte through the S-box
//   RCON_TBL : round constant per round index (0 and 11..15 map to 8'h00)
// ---------------------------------------------------------------------------
package DesignPkg;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   sbox_t;

  // Indexed directly by the 4-bit round input; out-of-range rounds read 00.
  localparam sbox_t RCON_TBL [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic sbox_t get_rcon(input logic [3:0] rnd);
    return RCON_TBL[rnd];
  endfunction

endpackage

// File: rtl/key_exp_if.sv
// ---------------------------------------------------------------------------
// key_exp_if
// Request/response bundle of the key-expansion block.
//   start_expansion    : request one round (master -> slave)
//   round              : round index 1..10 (master -> slave)
//   prev_key           : previous round key (master -> slave)
//   finished_expansion : one-cycle completion pulse (slave -> master)
//   next_key           : computed round key, held until next completion
// ---------------------------------------------------------------------------
interface key_exp_if;
  import DesignPkg::*;

  logic       start_expansion;
  logic [3:0] round;
  key_t       prev_key;
  logic       finished_expansion;
  key_t       next_key;

  modport master (
    output start_expansion, round, prev_key,
    input  finished_expansion, next_key
  );

  modport slave (
    input  start_expansion, round, prev_key,
    output finished_expansion, next_key
  );

endinterface

// File: rtl/key_exp_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (256-entry lookup).
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
  import DesignPkg::*;
(
  input  sbox_t i_byte,
  output sbox_t o_byte
);

  localparam sbox_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_exp.sv
// ---------------------------------------------------------------------------
// key_exp
// One AES-128 key-schedule round in three cycles (IDLE -> SUBST -> DONE).
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : key_exp_if.slave (start_expansion, round, prev_key in;
//           finished_expansion, next_key out, both registered)
// ---------------------------------------------------------------------------
module key_exp
  import DesignPkg::*;
(
  input  logic      clk,
  input  logic      reset,
  key_exp_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SUBST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0] r_state;
  key_t       r_key;        // request captured at the start edge
  logic [3:0] r_round;
  word_t      r_subw;       // SubWord(RotWord(w3)), registered in SUBST
  key_t       r_next_key;
  logic       r_finished;

  word_t w_rot;
  word_t w_sub;
  word_t w_t;
  word_t w_n0;
  word_t w_n1;
  word_t w_n2;
  word_t w_n3;

  // RotWord on the latched w3: byte 0 moves to the bottom.
  assign w_rot = {r_key[23:0], r_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Word chain: each new word folds in the one just produced.
  assign w_t  = r_subw ^ {get_rcon(r_round), 24'h000000};
  assign w_n0 = r_key[127:96] ^ w_t;
  assign w_n1 = r_key[95:64]  ^ w_n0;
  assign w_n2 = r_key[63:32]  ^ w_n1;
  assign w_n3 = r_key[31:0]   ^ w_n2;

  // Control FSM and datapath registers; starts are only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_key      <= 128'h0;
      r_round    <= 4'h0;
      r_subw     <= 32'h0;
      r_next_key <= 128'h0;
      r_finished <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_expansion) begin
            r_key   <= bus.prev_key;
            r_round <= bus.round;
            r_state <= ST_SUBST;
          end
        end
        ST_SUBST: begin
          r_subw  <= w_sub;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_next_key <= {w_n0, w_n1, w_n2, w_n3};
          r_finished <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.finished_expansion = r_finished;
  assign bus.next_key           = r_next_key;

endmodule

// File: tb/tb_key_exp.sv
// ---------------------------------------------------------------------------
// tb_key_exp
// Self-checking bench for key_exp: known-answer table, randomized rounds
// against a GF(2^8)-based reference model, and hand-written sequences for
// back-to-back starts, ignored starts and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_key_exp;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  key_exp_if bus ();

  key_exp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  // ---------------- reference model (from the AES field definition) -------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    // multiplicative inverse as a^254 (0 maps to 0)
    for (int i = 0; i < 254; i++) b = gmul(b, a);
    if (a == 8'h00) b = 8'h00;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h01;
    if (rnd == 4'd0 || rnd > 4'd10) return 8'h00;
    for (int i = 1; i < int'(rnd); i++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] ref_next(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w [4];
    logic [31:0] rot;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rot = {w[3][23:0], w[3][31:24]};
    for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox_ref(rot[8*i +: 8]);
    t[31:24] = t[31:24] ^ rcon_ref(rnd);
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request; the inputs are scrambled right after the start edge.
  task automatic run_op(input logic [127:0] k, input logic [3:0] rnd,
                        input logic [127:0] exp, input string name);
    @(negedge clk);
    bus.prev_key        = k;
    bus.round           = rnd;
    bus.start_expansion = 1'b1;
    @(posedge clk);
    #1;
    bus.start_expansion = 1'b0;
    bus.prev_key        = {$urandom, $urandom, $urandom, $urandom};
    bus.round           = rnd + 4'd1;
    chk({name, " fin@N"}, {127'h0, bus.finished_expansion}, 128'h0);
    @(posedge clk);
    #1;
    chk({name, " fin@N+1"}, {127'h0, bus.finished_expansion}, 128'h0);
    @(posedge clk);
    #1;
    chk({name, " fin@N+2"}, {127'h0, bus.finished_expansion}, 128'h1);
    chk({name, " key"}, bus.next_key, exp);
    @(posedge clk);
    #1;
    chk({name, " fin@N+3"}, {127'h0, bus.finished_expansion}, 128'h0);
    chk({name, " key held"}, bus.next_key, exp);
  endtask

  vec_t         kat [4];
  logic [127:0] kk [9];
  logic [3:0]   rr [9];
  logic [127:0] k1;
  logic [127:0] cap;
  logic [3:0]   rnd;
  int           pulses;

  initial begin
    n_vec = 0;
    n_bad = 0;
    kat[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    kat[1] = '{128'ha0fafe1788542cb123a339392a6c7605, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    kat[2] = '{128'hac7766f319fadc2128d12941575c006e, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    kat[3] = '{128'h0,                                4'd1,  128'h62636363626363636263636362636363};

    bus.start_expansion = 1'b0;
    bus.round           = 4'd0;
    bus.prev_key        = 128'h0;
    reset               = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset fin", {127'h0, bus.finished_expansion}, 128'h0);
    chk("reset key", bus.next_key, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    // known-answer table
    for (int i = 0; i < 4; i++) run_op(kat[i].key, kat[i].rnd, kat[i].exp, $sformatf("kat%0d", i));

    // random keys over the full 4-bit round range (0 and 11..15 give Rcon 00)
    for (int i = 0; i < 16; i++) begin
      k1  = {$urandom, $urandom, $urandom, $urandom};
      rnd = 4'($urandom_range(0, 15));
      run_op(k1, rnd, ref_next(k1, rnd), $sformatf("rand%0d r%0d", i, rnd));
    end

    // start held high: a new operation every 3 cycles, inputs changing each cycle
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      kk[c] = {$urandom, $urandom, $urandom, $urandom};
      rr[c] = 4'($urandom_range(0, 15));
      bus.prev_key        = kk[c];
      bus.round           = rr[c];
      bus.start_expansion = 1'b1;
      @(posedge clk);
      #1;
      if (c % 3 == 2) begin
        chk($sformatf("b2b fin c%0d", c), {127'h0, bus.finished_expansion}, 128'h1);
        chk($sformatf("b2b key c%0d", c), bus.next_key, ref_next(kk[c-2], rr[c-2]));
      end else begin
        chk($sformatf("b2b fin c%0d", c), {127'h0, bus.finished_expansion}, 128'h0);
      end
    end
    @(negedge clk);
    bus.start_expansion = 1'b0;

    // second start one cycle after the first is dropped
    k1 = kat[2].key;
    bus.prev_key        = k1;
    bus.round           = 4'd10;
    bus.start_expansion = 1'b1;
    @(posedge clk);
    #1;
    bus.start_expansion = 1'b0;
    @(negedge clk);
    bus.prev_key        = kat[0].key;
    bus.round           = 4'd1;
    bus.start_expansion = 1'b1;
    @(posedge clk);
    #1;
    bus.start_expansion = 1'b0;
    pulses = 0;
    cap    = 128'h0;
    for (int c = 0; c < 6; c++) begin
      if (bus.finished_expansion) begin
        pulses++;
        cap = bus.next_key;
      end
      @(posedge clk);
      #1;
    end
    chk("ignored start pulses", 128'(pulses), 128'd1);
    chk("ignored start key", cap, kat[2].exp);

    // reset during SUBST aborts the operation; reset also beats start
    @(negedge clk);
    bus.prev_key        = kat[1].key;
    bus.round           = 4'd2;
    bus.start_expansion = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    bus.start_expansion = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.finished_expansion) pulses++;
    end
    chk("abort pulses", 128'(pulses), 128'd0);
    chk("abort key", bus.next_key, 128'h0);
    run_op(kat[0].key, 4'd1, kat[0].exp, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
